// File: rtl/unsigned_shift_add_mac.sv
// Sequential shift-and-add multiply-accumulate: o_reg_P = data_in_1 * data_in_2 + data_in_3.
// Each multiplier bit takes an ADD/SHIFT pair. Start/done handshake and debug outputs mirror the restoring divider.
module unsigned_shift_add_mac #(
    parameter int WID  = 4,
    parameter int CWID = $clog2(WID + 1)
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WID-1:0]       data_in_1,
    input  logic [WID-1:0]       data_in_2,
    input  logic [WID-1:0]       data_in_3,
    output logic [2*WID-1:0]     o_reg_P,
    output logic [2:0]           p_STATE,
    output logic [CWID-1:0]      Count_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        ACC   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [WID-1:0]      m_reg;
    logic [WID-1:0]      c_reg;
    logic [WID:0]        a_reg;
    logic [WID-1:0]      q_reg;
    logic [CWID-1:0]     cnt_reg;
    logic [2*WID-1:0]    p_reg;

    logic [WID:0]        a_sum;
    logic [WID:0]        a_shift;
    logic [WID-1:0]      q_shift;
    logic [2*WID-1:0]    acc_sum;

    // Carry lands in a_sum[WID]; the top bit of A is always clear before an add.
    assign a_sum   = {1'b0, a_reg[WID-1:0]} + {1'b0, m_reg};
    assign a_shift = {1'b0, a_reg[WID:1]};
    assign acc_sum = {a_reg[WID-1:0], q_reg} + {{WID{1'b0}}, c_reg};

    // {A,Q} shifted right as one register: A's LSB enters the top of Q.
    generate
        for (genvar gi = 0; gi < WID; gi++) begin : g_qshift
            if (gi == WID - 1) begin : g_top
                assign q_shift[gi] = a_reg[0];
            end else begin : g_mid
                assign q_shift[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? LOAD : IDLE;
            LOAD:    state_next = ADD;
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = (cnt_reg == CWID'(1)) ? ACC : ADD;
            ACC:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            c_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD: begin
                    m_reg   <= data_in_1;
                    q_reg   <= data_in_2;
                    c_reg   <= data_in_3;
                    a_reg   <= '0;
                    cnt_reg <= CWID'(WID);
                end
                ADD: begin
                    if (q_reg[0]) begin
                        a_reg <= a_sum;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_shift;
                    q_reg   <= q_shift;
                    cnt_reg <= cnt_reg - CWID'(1);
                end
                ACC: begin
                    p_reg <= acc_sum;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_reg_P   = p_reg;
    assign p_STATE   = state_reg;
    assign Count_out = cnt_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule
